// File: rtl/wb_pkg.sv
// Shared widths and the buffered write-back entry layout for the write-back arbiter.
package wb_pkg;

  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic             live;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Return FIFO for load/MDU results: circular storage with per-entry WAW kill
// and two combinational hazard lookup ports over the live entries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  input  logic                     kill_en,
  input  logic [AW-1:0]            kill_addr,
  input  logic [AW-1:0]            haz_addr_1,
  input  logic [AW-1:0]            haz_addr_2,
  output logic                     head_live,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     haz_1,
  output logic                     haz_2
);

  localparam int PW = $clog2(DEPTH);

  logic          live_q [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // A popped slot drops its live bit so stale entries never raise a hazard.
  // A push that collides with a same-cycle ALU write lands already killed,
  // since the ALU result is the younger of the two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        live_q[i] <= 1'b0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (addr_q[i] == kill_addr)) begin
          live_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        live_q[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      if (push) begin
        live_q[wr_ptr] <= !(kill_en && (kill_addr == push_addr));
        addr_q[wr_ptr] <= push_addr;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_live = live_q[rd_ptr];
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  always_comb begin
    haz_1 = 1'b0;
    haz_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == haz_addr_1)) haz_1 = 1'b1;
      if (live_q[i] && (addr_q[i] == haz_addr_2)) haz_2 = 1'b1;
    end
    if (haz_addr_1 == '0) haz_1 = 1'b0;
    if (haz_addr_2 == '0) haz_2 = 1'b0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: the ALU always wins the register-file write port, and
// buffered load/MDU returns drain from the FIFO whenever the ALU slot is free.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   ALU_WE,
  input  logic [AW-1:0]          ALU_ADDR,
  input  logic [DW-1:0]          ALU_DATA,
  input  logic                   LD_VALID,
  output logic                   LD_READY,
  input  logic [AW-1:0]          LD_ADDR,
  input  logic [DW-1:0]          LD_DATA,
  input  logic [AW-1:0]          RD_ADDR_1,
  input  logic [AW-1:0]          RD_ADDR_2,
  output logic                   HAZ_1,
  output logic                   HAZ_2,
  output logic                   WE,
  output logic [AW-1:0]          WR_ADDR,
  output logic [DW-1:0]          W_DATA,
  output logic [$clog2(DEPTH):0] CNT
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          alu_busy;
  logic          push;
  logic          pop;
  logic          head_live;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [CW-1:0] count;

  assign alu_busy = ALU_WE && (ALU_ADDR != '0);
  assign LD_READY = (count < FULL_CNT);
  // Returns to r0 are accepted upstream but never stored.
  assign push     = LD_VALID && LD_READY && (LD_ADDR != '0);
  assign pop      = !alu_busy && (count != '0);
  assign CNT      = count;

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .push       (push),
    .push_addr  (LD_ADDR),
    .push_data  (LD_DATA),
    .pop        (pop),
    .kill_en    (alu_busy),
    .kill_addr  (ALU_ADDR),
    .haz_addr_1 (RD_ADDR_1),
    .haz_addr_2 (RD_ADDR_2),
    .head_live  (head_live),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .count      (count),
    .haz_1      (HAZ_1),
    .haz_2      (HAZ_2)
  );

  // A killed head still consumes its slot; it simply writes with WE low.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      WE      <= 1'b0;
      WR_ADDR <= '0;
      W_DATA  <= '0;
    end else if (alu_busy) begin
      WE      <= 1'b1;
      WR_ADDR <= ALU_ADDR;
      W_DATA  <= ALU_DATA;
    end else if (pop) begin
      WE      <= head_live;
      WR_ADDR <= head_addr;
      W_DATA  <= head_data;
    end else begin
      WE      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter against a queue-based model
// of the write-back ordering rules.
module tb_wb_arbiter;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ALU_WE = 1'b0;
  logic [4:0]  ALU_ADDR = '0;
  logic [31:0] ALU_DATA = '0;
  logic        LD_VALID = 1'b0;
  logic        LD_READY;
  logic [4:0]  LD_ADDR = '0;
  logic [31:0] LD_DATA = '0;
  logic [4:0]  RD_ADDR_1 = '0;
  logic [4:0]  RD_ADDR_2 = '0;
  logic        HAZ_1;
  logic        HAZ_2;
  logic        WE;
  logic [4:0]  WR_ADDR;
  logic [31:0] W_DATA;
  logic [2:0]  CNT;

  wb_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .ALU_WE    (ALU_WE),
    .ALU_ADDR  (ALU_ADDR),
    .ALU_DATA  (ALU_DATA),
    .LD_VALID  (LD_VALID),
    .LD_READY  (LD_READY),
    .LD_ADDR   (LD_ADDR),
    .LD_DATA   (LD_DATA),
    .RD_ADDR_1 (RD_ADDR_1),
    .RD_ADDR_2 (RD_ADDR_2),
    .HAZ_1     (HAZ_1),
    .HAZ_2     (HAZ_2),
    .WE        (WE),
    .WR_ADDR   (WR_ADDR),
    .W_DATA    (W_DATA),
    .CNT       (CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          live;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit          exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  bit          model_accepted;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rf_dut [32];
  int          ld_idx;
  logic [4:0]  exp_order [5];

  // Register file as seen through the DUT write port.
  always @(posedge CLK) begin
    if (WE) rf_dut[WR_ADDR] <= W_DATA;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit modelHaz(input logic [4:0] ra);
    if (ra == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].live && q[i].addr == ra) return 1'b1;
    return 1'b0;
  endfunction

  // One edge of write-back behaviour: ALU wins the port, otherwise the oldest
  // buffered return leaves; new returns join the back; an ALU write kills
  // every older buffered write to the same register.
  task automatic modelStep(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                           input logic lv, input logic [4:0] la, input logic [31:0] ldat);
    bit   busy;
    ent_t e;
    busy = aw && (aa != 5'd0);
    model_accepted = lv && (q.size() < DEPTH);
    if (busy) begin
      exp_we = 1'b1; exp_addr = aa; exp_data = ad;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      exp_we = e.live; exp_addr = e.addr; exp_data = e.data;
    end else begin
      exp_we = 1'b0;
    end
    if (model_accepted && la != 5'd0) begin
      e.live = 1'b1; e.addr = la; e.data = ldat;
      q.push_back(e);
    end
    if (busy) foreach (q[i]) if (q[i].addr == aa) q[i].live = 1'b0;
  endtask

  // Entered and left at one time unit after a rising edge.
  task automatic applyStimulus(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                               input logic lv, input logic [4:0] la, input logic [31:0] ldat,
                               input logic [4:0] r1, input logic [4:0] r2);
    ALU_WE = aw; ALU_ADDR = aa; ALU_DATA = ad;
    LD_VALID = lv; LD_ADDR = la; LD_DATA = ldat;
    RD_ADDR_1 = r1; RD_ADDR_2 = r2;
    #1;
    checkOutput("haz_1", 32'(HAZ_1), 32'(modelHaz(r1)));
    checkOutput("haz_2", 32'(HAZ_2), 32'(modelHaz(r2)));
    checkOutput("ld_ready", 32'(LD_READY), 32'(q.size() < DEPTH));
    modelStep(aw, aa, ad, lv, la, ldat);
    @(posedge CLK);
    #1;
    checkOutput("we", 32'(WE), 32'(exp_we));
    checkOutput("wr_addr", 32'(WR_ADDR), 32'(exp_addr));
    checkOutput("w_data", W_DATA, exp_data);
    checkOutput("cnt", 32'(CNT), 32'(q.size()));
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  task automatic doReset();
    RESET_N = 1'b0;
    ALU_WE = 1'b0; LD_VALID = 1'b0; RD_ADDR_1 = '0; RD_ADDR_2 = '0;
    #1;
    checkOutput("rst_we", 32'(WE), 32'd0);
    checkOutput("rst_cnt", 32'(CNT), 32'd0);
    checkOutput("rst_ld_ready", 32'(LD_READY), 32'd1);
    checkOutput("rst_wr_addr", 32'(WR_ADDR), 32'd0);
    checkOutput("rst_w_data", W_DATA, 32'd0);
    q.delete();
    exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    @(posedge CLK);
    #2;
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    foreach (rf_dut[i]) rf_dut[i] = '0;
    @(posedge CLK);
    #1;
    doReset();

    // Reset mid-stream with three buffered returns.
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 5'd20, 32'h100 + 32'(k), 1'b1, 5'(k + 1), 32'h200 + 32'(k), 5'd0, 5'd0);
    checkOutput("t1_cnt_before", 32'(CNT), 32'd3);
    doReset();
    for (int k = 0; k < 3; k++) begin
      idleCycle();
      checkOutput("t1_no_write", 32'(WE), 32'd0);
    end

    // Single return reaches the write port two edges later.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    checkOutput("t2_we_early", 32'(WE), 32'd0);
    idleCycle();
    checkOutput("t2_we", 32'(WE), 32'd1);
    checkOutput("t2_addr", 32'(WR_ADDR), 32'd5);
    checkOutput("t2_data", W_DATA, 32'hDEADBEEF);

    // ALU busy six cycles while five returns queue; r5 is held until space.
    exp_order = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    ld_idx = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(c < 6, 5'(16 + (c % 4)), 32'h3000 + 32'(c),
                    ld_idx < 5, 5'(ld_idx + 1), 32'h4000 + 32'(ld_idx), 5'd0, 5'd0);
      if (model_accepted && ld_idx < 5) ld_idx++;
      if (c == 3) begin
        checkOutput("t3_cnt_full", 32'(CNT), 32'd4);
        checkOutput("t3_ready_low", 32'(LD_READY), 32'd0);
      end
      if (c >= 6 && c <= 10) begin
        checkOutput("t3_drain_we", 32'(WE), 32'd1);
        checkOutput("t3_drain_addr", 32'(WR_ADDR), 32'(exp_order[c - 6]));
      end
    end

    // WAW kill with the return buffered first.
    rf_dut[7] = 32'd0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd1, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd7, 32'd2, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    checkOutput("t4a_alu_we", 32'(WE), 32'd1);
    checkOutput("t4a_alu_data", W_DATA, 32'd2);
    idleCycle();
    checkOutput("t4a_killed_we", 32'(WE), 32'd0);
    idleCycle();
    checkOutput("t4a_rf7", rf_dut[7], 32'd2);

    // WAW kill with the return pushed in the same cycle as the ALU write.
    rf_dut[7] = 32'd0;
    applyStimulus(1'b1, 5'd7, 32'd2, 1'b1, 5'd7, 32'd1, 5'd7, 5'd0);
    checkOutput("t4b_alu_we", 32'(WE), 32'd1);
    checkOutput("t4b_haz_dead", 32'(HAZ_1), 32'd0);
    idleCycle();
    checkOutput("t4b_killed_we", 32'(WE), 32'd0);
    idleCycle();
    checkOutput("t4b_rf7", rf_dut[7], 32'd2);

    // Hazard lookup on a buffered r9, then a discarded return to r0.
    applyStimulus(1'b1, 5'd3, 32'd33, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd3, 32'd34, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    checkOutput("t5_haz1_set", 32'(HAZ_1), 32'd1);
    checkOutput("t5_haz2_clear", 32'(HAZ_2), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    checkOutput("t5_haz1_popped", 32'(HAZ_1), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
    checkOutput("t5_r0_cnt", 32'(CNT), 32'd0);
    checkOutput("t5_r0_haz", 32'(HAZ_1), 32'd0);

    // Steady push/pop for 20 cycles wraps the pointers several times.
    applyStimulus(1'b1, 5'd20, 32'd0, 1'b1, 5'd10, 32'hA0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd20, 32'd0, 1'b1, 5'd11, 32'hA1, 5'd0, 5'd0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(12 + (k % 8)), 32'hB00 + 32'(k), 5'(12 + (k % 8)), 5'd10);
      checkOutput("t6_cnt_steady", 32'(CNT), 32'd2);
    end
    for (int k = 0; k < 3; k++) idleCycle();

    // Random traffic over a small register range to force collisions.
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    // Continuous ALU traffic: FIFO fills and never drains.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 5'($urandom_range(1, 7)), $urandom,
                    1'b1, 5'($urandom_range(1, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    checkOutput("full_ready_low", 32'(LD_READY), 32'd0);
    for (int k = 0; k < 8; k++) idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
